// File: rtl/vga_mem_pkg.sv
// vga_mem_pkg: shared owner/state encodings and default widths for the VGA/CPU RAM arbiter
package vga_mem_pkg;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 17;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_VGA = 2'd1, OWN_CPU = 2'd2} owner_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_VGA = 2'd1, ST_CPU = 2'd2} state_t;
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;
  function automatic owner_t state_owner(input state_t s);
    return s == ST_VGA ? OWN_VGA : s == ST_CPU ? OWN_CPU : OWN_NONE;
  endfunction
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep {valid,owner} shift register aligning read tags with RAM read data
module rd_tag_pipe
  import vga_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);
  rd_tag_t r_pipe [DEPTH];
  // shift tags one stage per cycle; reset drops every in-flight read
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_ram_arbiter.sv
// vga_ram_arbiter: shares one RAM port between VGA fetch (priority) and CPU with bounded starvation
module vga_ram_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RAM_LAT    = 1,
  parameter int MAX_VBURST = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vga_req,
  input  logic              i_vga_urgent,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic              o_vga_gnt,
  output logic              o_vga_rvalid,
  output logic [DATA_W-1:0] o_vga_rdata,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_vcnt, w_vcnt_nxt;
  logic              w_vga_win, w_cpu_win;
  logic              r_ram_en, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_vga_rvalid, r_cpu_rvalid;
  logic [DATA_W-1:0] r_vga_rdata, r_cpu_rdata;
  rd_tag_t           w_tag_in, w_tag_out;
  logic              w_vga_ret, w_cpu_ret;
  // arbitration: VGA wins unless the CPU has waited out a full burst and VGA is not urgent
  always_comb begin
    w_vga_win   = i_vga_req && (!i_cpu_req || r_vcnt < 4'(MAX_VBURST) || i_vga_urgent);
    w_cpu_win   = i_cpu_req && !w_vga_win;
    w_state_nxt = w_vga_win ? ST_VGA : w_cpu_win ? ST_CPU : ST_IDLE;
    w_vcnt_nxt  = (!i_cpu_req || w_cpu_win) ? 4'd0 :
                  (w_vga_win && r_vcnt < 4'(MAX_VBURST)) ? r_vcnt + 4'd1 : r_vcnt;
  end
  // state register holds the owner of the access issued this cycle, plus the burst counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_vcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_vcnt  <= w_vcnt_nxt;
    end
  end
  // registered RAM command; address and write data hold through idle cycles
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_en <= w_vga_win || w_cpu_win;
      r_ram_we <= w_cpu_win && i_cpu_we;
      if (w_vga_win) r_ram_addr <= i_vga_addr;
      else if (w_cpu_win) r_ram_addr <= i_cpu_addr;
      if (w_cpu_win) r_ram_wdata <= i_cpu_wdata;
    end
  end
  assign w_tag_in = '{valid: r_ram_en && !r_ram_we, owner: state_owner(r_state)};
  rd_tag_pipe #(.DEPTH(RAM_LAT)) u_tag_pipe (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );
  assign w_vga_ret = w_tag_out.valid && w_tag_out.owner == OWN_VGA;
  assign w_cpu_ret = w_tag_out.valid && w_tag_out.owner == OWN_CPU;
  // registered read return steered by the tag at the pipe tail; rdata holds between pulses
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vga_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_vga_rdata  <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_vga_rvalid <= w_vga_ret;
      r_cpu_rvalid <= w_cpu_ret;
      if (w_vga_ret) r_vga_rdata <= i_ram_rdata;
      if (w_cpu_ret) r_cpu_rdata <= i_ram_rdata;
    end
  end
  assign o_vga_gnt    = r_state == ST_VGA;
  assign o_cpu_gnt    = r_state == ST_CPU;
  assign o_ram_en     = r_ram_en;
  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wdata  = r_ram_wdata;
  assign o_vga_rvalid = r_vga_rvalid;
  assign o_vga_rdata  = r_vga_rdata;
  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_cpu_rdata  = r_cpu_rdata;
endmodule
